// File: rtl/timer_sched_pkg.sv
// Shared state encoding, timer register map and control words for timer_delay_scheduler.
// Defining TIMER_SCHED_WATCHDOG_EN adds the ABORT state used by the watchdog path.
package timer_sched_pkg;

`ifdef TIMER_SCHED_WATCHDOG_EN
    typedef enum logic [3:0] {
        IDLE, WR_PL, WR_PH, SETTLE, WR_CTRL, WAIT_IRQ, WR_STAT, DONE, ABORT
    } state_t;
`else
    typedef enum logic [3:0] {
        IDLE, WR_PL, WR_PH, SETTLE, WR_CTRL, WAIT_IRQ, WR_STAT, DONE
    } state_t;
`endif

    localparam logic [2:0] STATUS   = 3'd0;
    localparam logic [2:0] CONTROL  = 3'd1;
    localparam logic [2:0] PERIOD_L = 3'd2;
    localparam logic [2:0] PERIOD_H = 3'd3;

    localparam logic [15:0] START_ITO = 16'h0005;
    localparam logic [15:0] STOP      = 16'h0008;

    localparam int WD_MARGIN = 64;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: the first requester above last_grant wins, wrapping to index 0.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [2:0]         grant_id
);

    logic found;

    // Two passes: indices after the last grant first, then wrap to the lowest index.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (3'(i) > last_grant)) begin
                grant[i] = 1'b1;
                grant_id = 3'(i);
                found    = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                grant[i] = 1'b1;
                grant_id = 3'(i);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_delay_scheduler.sv
// Shares one interval timer among NUM_REQ requesters, programming a one-shot delay per grant.
// Defining TIMER_SCHED_WATCHDOG_EN adds a watchdog that aborts a grant whose interrupt never arrives.
module timer_delay_scheduler
    import timer_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DELAY_W = 32
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DELAY_W-1:0] req_delay,
    output logic [NUM_REQ-1:0]         done,
    output logic [NUM_REQ-1:0]         err,
    output logic                       busy,
    output logic [2:0]                 cur_id,
    output logic [2:0]                 tmr_address,
    output logic                       tmr_chipselect,
    output logic                       tmr_write_n,
    output logic [15:0]                tmr_writedata,
    input  logic                       tmr_irq
);

    state_t               state, next_state;
    logic [2:0]           last_grant;
    logic [DELAY_W-1:0]   delay_q, sel_delay;
    logic [NUM_REQ-1:0]   grant, id_onehot;
    logic [2:0]           grant_id;
    logic                 start;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arbiter (
        .req        (req),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_id   (grant_id)
    );

    always_comb begin
        sel_delay = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) sel_delay = sel_delay | req_delay[i*DELAY_W +: DELAY_W];
        end
    end

    assign start     = (state == IDLE) && (|req);
    assign busy      = (state != IDLE);
    assign id_onehot = NUM_REQ'(1) << cur_id;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    // Pointer starts at the top index so requester 0 wins the first arbitration.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_id     <= '0;
            delay_q    <= '0;
            last_grant <= 3'(NUM_REQ - 1);
        end else if (start) begin
            cur_id     <= grant_id;
            delay_q    <= sel_delay;
            last_grant <= grant_id;
        end
    end

`ifdef TIMER_SCHED_WATCHDOG_EN
    logic [32:0] wd_cnt;
    logic        aborted;
    logic        wd_expired;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt  <= '0;
            aborted <= 1'b0;
        end else begin
            if (state == WR_CTRL)       wd_cnt <= {1'b0, delay_q} + 33'(WD_MARGIN);
            else if (state == WAIT_IRQ) wd_cnt <= wd_cnt - 33'd1;
            if (start)                  aborted <= 1'b0;
            else if (state == ABORT)    aborted <= 1'b1;
        end
    end

    assign wd_expired = (wd_cnt == 33'd1);
`endif

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (|req) next_state = WR_PL;
            WR_PL:    next_state = (delay_q == '0) ? DONE : WR_PH;
            WR_PH:    next_state = SETTLE;
            SETTLE:   next_state = WR_CTRL;
            WR_CTRL:  next_state = WAIT_IRQ;
`ifdef TIMER_SCHED_WATCHDOG_EN
            WAIT_IRQ: begin
                if (tmr_irq)         next_state = WR_STAT;
                else if (wd_expired) next_state = ABORT;
            end
            ABORT:    next_state = WR_STAT;
`else
            WAIT_IRQ: if (tmr_irq) next_state = WR_STAT;
`endif
            WR_STAT:  next_state = DONE;
            DONE:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // A zero delay passes through the WR_PL slot without touching the timer.
    always_comb begin
        tmr_chipselect = 1'b0;
        tmr_write_n    = 1'b1;
        tmr_address    = STATUS;
        tmr_writedata  = '0;
        done           = '0;
        err            = '0;
        case (state)
            WR_PL: begin
                if (delay_q != '0) begin
                    tmr_chipselect = 1'b1;
                    tmr_write_n    = 1'b0;
                    tmr_address    = PERIOD_L;
                    tmr_writedata  = delay_q[15:0];
                end
            end
            WR_PH: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = PERIOD_H;
                tmr_writedata  = delay_q[31:16];
            end
            WR_CTRL: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = CONTROL;
                tmr_writedata  = START_ITO;
            end
            WR_STAT: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = STATUS;
                tmr_writedata  = 16'h0000;
            end
`ifdef TIMER_SCHED_WATCHDOG_EN
            ABORT: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = CONTROL;
                tmr_writedata  = STOP;
            end
            DONE: begin
                if (aborted) err  = id_onehot;
                else         done = id_onehot;
            end
`else
            DONE: done = id_onehot;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_timer_delay_scheduler.sv
// Self-checking bench for timer_delay_scheduler with a behavioural one-shot timer model.
// Build with TIMER_SCHED_WATCHDOG_EN to add the watchdog abort sequence.
module tb_timer_delay_scheduler;

    localparam int NUM_REQ = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [3:0]   req = '0;
    logic [127:0] req_delay = '0;
    logic [3:0]   done, err;
    logic         busy;
    logic [2:0]   cur_id, tmr_address;
    logic         tmr_chipselect, tmr_write_n;
    logic [15:0]  tmr_writedata;
    logic         tmr_irq;

    timer_delay_scheduler #(.NUM_REQ(NUM_REQ), .DELAY_W(32)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req            (req),
        .req_delay      (req_delay),
        .done           (done),
        .err            (err),
        .busy           (busy),
        .cur_id         (cur_id),
        .tmr_address    (tmr_address),
        .tmr_chipselect (tmr_chipselect),
        .tmr_write_n    (tmr_write_n),
        .tmr_writedata  (tmr_writedata),
        .tmr_irq        (tmr_irq)
    );

    always #5 clk = ~clk;

    // Timer model: irq rises delay+1 cycles after the start strobe is accepted.
    logic        model_irq, running, irq_block = 1'b0;
    logic [31:0] period, cnt;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            model_irq <= 1'b0;
            running   <= 1'b0;
            period    <= '0;
            cnt       <= '0;
        end else if (tmr_chipselect && !tmr_write_n) begin
            case (tmr_address)
                3'd0: model_irq <= 1'b0;
                3'd1: begin
                    if (tmr_writedata[2]) begin
                        running <= 1'b1;
                        cnt     <= period;
                    end else if (tmr_writedata[3]) begin
                        running <= 1'b0;
                    end
                end
                3'd2: period[15:0]  <= tmr_writedata;
                3'd3: period[31:16] <= tmr_writedata;
                default: ;
            endcase
        end else if (running) begin
            if (cnt == 0) begin
                model_irq <= 1'b1;
                running   <= 1'b0;
            end else begin
                cnt <= cnt - 1;
            end
        end
    end

    assign tmr_irq = model_irq & ~irq_block;

    typedef struct {
        int          kind;
        logic [2:0]  addr;
        logic [15:0] data;
        logic [3:0]  vec;
    } ev_t;

    typedef struct {
        int          id;
        logic [31:0] delay;
        logic [15:0] exp_pl;
        logic [15:0] exp_ph;
        int          exp_lat;
    } vec_t;

    ev_t  exp_q[$];
    int   grants[$];
    int   total = 0, bad = 0, cycle = 0;
    int   grant_cycle = 0, done_cycle = 0, stop_cycle = 0;
    logic saw_done = 1'b0, prev_busy = 1'b0;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic void push_op(input int id, input logic [15:0] pl, input logic [15:0] ph,
                                    input bit use_timer, input bit aborted);
        if (use_timer) begin
            exp_q.push_back('{0, 3'd2, pl, 4'd0});
            exp_q.push_back('{0, 3'd3, ph, 4'd0});
            exp_q.push_back('{0, 3'd1, 16'h0005, 4'd0});
            if (aborted) exp_q.push_back('{0, 3'd1, 16'h0008, 4'd0});
            exp_q.push_back('{0, 3'd0, 16'h0000, 4'd0});
        end
        exp_q.push_back('{aborted ? 2 : 1, 3'd0, 16'h0, 4'(1 << id)});
    endfunction

    // One cycle: sample at the falling edge and score any write or completion pulse.
    task automatic tick();
        ev_t e;
        @(negedge clk);
        cycle++;
        saw_done = 1'b0;
        if (busy && !prev_busy) begin
            grant_cycle = cycle;
            grants.push_back(int'(cur_id));
        end
        prev_busy = busy;
        if (tmr_chipselect && !tmr_write_n) begin
            if (exp_q.size() == 0) begin
                check_output("spurious_write", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check_output("write_expected", e.kind, 0);
                check_output("write_addr", tmr_address, e.addr);
                check_output("write_data", tmr_writedata, e.data);
                if (tmr_address == 3'd1 && tmr_writedata == 16'h0008) stop_cycle = cycle;
            end
        end
        if (done != 0 || err != 0) begin
            saw_done   = 1'b1;
            done_cycle = cycle;
            if (exp_q.size() == 0) begin
                check_output("spurious_done", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check_output("done_vec", done, (e.kind == 1) ? e.vec : 4'd0);
                check_output("err_vec", err, (e.kind == 2) ? e.vec : 4'd0);
            end
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        int start, n;
        push_op(v.id, v.exp_pl, v.exp_ph, 1'b1, 1'b0);
        req_delay[v.id*32 +: 32] = v.delay;
        req[v.id] = 1'b1;
        start = cycle;
        tick();
        check_output("grant_busy", busy, 1);
        check_output("grant_id", cur_id, v.id);
        n = 0;
        while (!saw_done && n < int'(v.delay) + 40) begin
            tick();
            n++;
        end
        check_output("done_seen", saw_done, 1);
        if (saw_done) check_output("done_latency", done_cycle - (start + 1), v.exp_lat);
        req[v.id] = 1'b0;
        tick();
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_busy"}, busy, 0);
        check_output({tag, "_cs"}, tmr_chipselect, 0);
        check_output({tag, "_write_n"}, tmr_write_n, 1);
        check_output({tag, "_addr"}, tmr_address, 0);
        check_output({tag, "_wdata"}, tmr_writedata, 0);
        check_output({tag, "_done"}, done, 0);
        check_output({tag, "_err"}, err, 0);
        check_output({tag, "_cur_id"}, cur_id, 0);
    endtask

    initial begin
        vec_t vecs[4];
        int   exp_order[5];
        int   ndone, n, start;

        vecs[0] = '{1, 32'd100,         16'd100,   16'd0, 107};
        vecs[1] = '{3, 32'd5,           16'd5,     16'd0, 12};
        vecs[2] = '{2, 32'h0000_0123,   16'h0123,  16'd0, 298};
        vecs[3] = '{0, 32'h0001_0000,   16'h0000,  16'd1, 65543};
        exp_order = '{0, 1, 2, 3, 0};

        tick();
        tick();
        check_reset_outputs("reset");
        reset_n = 1'b1;
        tick();

        // Four simultaneous requesters, requester 0 keeps asking.
        for (int i = 0; i < 5; i++) push_op(exp_order[i], 16'd10, 16'd0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) req_delay[i*32 +: 32] = 32'd10;
        grants.delete();
        req = 4'b1111;
        ndone = 0;
        n = 0;
        while (ndone < 5 && n < 1000) begin
            tick();
            n++;
            if (saw_done) begin
                ndone++;
                if (ndone >= 2 && ndone <= 4) req[ndone-1] = 1'b0;
                else if (ndone == 5) req = '0;
            end
        end
        check_output("rr_done_count", ndone, 5);
        check_output("rr_grant_count", grants.size(), 5);
        for (int i = 0; i < 5 && i < grants.size(); i++)
            check_output($sformatf("rr_grant_%0d", i), grants[i], exp_order[i]);
        tick();
        tick();

        for (int i = 0; i < 4; i++) apply_stimulus(vecs[i]);

        // Zero delay: no timer writes, done two cycles after the request.
        push_op(2, 16'd0, 16'd0, 1'b0, 1'b0);
        req_delay[2*32 +: 32] = 32'd0;
        req[2] = 1'b1;
        start = cycle;
        n = 0;
        while (!saw_done && n < 6) begin
            tick();
            n++;
        end
        check_output("zero_done_seen", saw_done, 1);
        check_output("zero_done_latency", done_cycle - start, 2);
        req[2] = 1'b0;
        tick();
        tick();

        // Reset while waiting on the timer: operation abandoned silently.
        exp_q.push_back('{0, 3'd2, 16'd50, 4'd0});
        exp_q.push_back('{0, 3'd3, 16'd0, 4'd0});
        exp_q.push_back('{0, 3'd1, 16'h0005, 4'd0});
        req_delay[1*32 +: 32] = 32'd50;
        req[1] = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check_output("midop_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midop_reset");
        check_output("midop_writes_consumed", exp_q.size(), 0);
        req = '0;
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 70; i++) tick();
        check_output("post_reset_idle", busy, 0);
        apply_stimulus('{3, 32'd3, 16'd3, 16'd0, 10});

`ifdef TIMER_SCHED_WATCHDOG_EN
        irq_block = 1'b1;
        push_op(2, 16'd20, 16'd0, 1'b1, 1'b1);
        req_delay[2*32 +: 32] = 32'd20;
        req[2] = 1'b1;
        start = cycle;
        stop_cycle = 0;
        n = 0;
        while (!saw_done && n < 300) begin
            tick();
            n++;
        end
        check_output("wd_err_seen", saw_done, 1);
        check_output("wd_stop_cycle", stop_cycle - (start + 1), 88);
        req[2] = 1'b0;
        irq_block = 1'b0;
        tick();
        tick();
`endif

        check_output("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timer_delay_scheduler.md
TIMER_DELAY_SCHEDULER -- requirements
Module: timer_delay_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters (2..8) sharing one interval timer.
REQ-002 Parameter DELAY_W, default 32, delay operand width; fixed at 32 to match the timer period registers.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 req  input  NUM_REQ  level request per requester; held until its done or err pulse.
REQ-006 req_delay  input  NUM_REQ*DELAY_W  per-requester delay in clk cycles; sampled at grant only.
REQ-007 done  output  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-008 err  output  NUM_REQ  one-cycle watchdog-abort pulse (only with the watchdog macro).
REQ-009 busy  output  1  high from grant through done/err.
REQ-010 cur_id  output  3  index of the granted requester; valid while busy.
REQ-011 tmr_address  output  3  timer register address: 0 status, 1 control, 2 period_l, 3 period_h.
REQ-012 tmr_chipselect, tmr_write_n  output  1 each  timer write strobe; write_n is active-low.
REQ-013 tmr_writedata  output  16  timer write data.
REQ-014 tmr_irq  input  1  timer interrupt, level, cleared by a status write.

Function
REQ-015 The FSM SHALL use states IDLE, WR_PL, WR_PH, SETTLE, WR_CTRL, WAIT_IRQ, WR_STAT, DONE, plus ABORT with the watchdog.
REQ-016 IDLE: when any req bit is set, grant by round-robin starting at the index after the last grant, with wrap; latch id and delay; go to WR_PL.
REQ-017 A latched delay of 0 SHALL skip timer access and go directly to DONE.
REQ-018 Each WR_* state is exactly one cycle with chipselect=1 and write_n=0; every other state has chipselect=0 and write_n=1.
REQ-019 WR_PL writes delay[15:0] to address 2; WR_PH writes delay[31:16] to address 3.
REQ-020 SETTLE is one idle cycle so that the timer's force_reload completes before the start strobe.
REQ-021 WR_CTRL writes 0x0005 (START|ITO, CONT=0) to address 1, then the FSM enters WAIT_IRQ.
REQ-022 WAIT_IRQ exits to WR_STAT on the first cycle in which tmr_irq=1.
REQ-023 WR_STAT writes 0x0000 to address 0 to clear the timeout.
REQ-024 DONE pulses done[id] for one cycle, deasserts busy, and returns to IDLE.
REQ-025 Grant latency SHALL be 1 cycle from req to WR_PL.
REQ-026 Timer-path latency from grant to done SHALL be delay+7 cycles, bounded by timer behaviour.
REQ-027 Request changes while busy are ignored; a requester that drops req mid-operation still receives its done pulse.
REQ-028 A tmr_irq already high in IDLE SHALL be ignored; only tmr_irq observed in WAIT_IRQ counts.
REQ-029 Simultaneous requests SHALL be served strictly round-robin with no starvation; worst-case wait is NUM_REQ-1 operations.

Reset
REQ-030 On reset_n=0 the FSM SHALL enter IDLE, set done=0, err=0, busy=0, cur_id=0, tmr_chipselect=0, tmr_write_n=1, tmr_address=0 and tmr_writedata=0.
REQ-031 On reset, the round-robin pointer SHALL be set so that req[0] wins first.
REQ-032 A reset asserted mid-operation SHALL abandon the operation with no done pulse; the timer is reset by the same reset_n.

Configuration
REQ-033 Macro TIMER_SCHED_WATCHDOG_EN SHALL enable a 33-bit watchdog counter loaded with delay+64 on entry to WAIT_IRQ.
REQ-034 With the watchdog enabled, expiry before tmr_irq SHALL cause ABORT: write 0x0008 (STOP) to address 1, then WR_STAT, then pulse err[id] instead of done.
REQ-035 Without TIMER_SCHED_WATCHDOG_EN, err is tied to 0, ABORT does not exist, and WAIT_IRQ waits indefinitely.

Structure
REQ-036 Package timer_sched_pkg SHALL hold the state enum, the register address constants (STATUS=0, CONTROL=1, PERIOD_L=2, PERIOD_H=3), the control constants (START_ITO=16'h0005, STOP=16'h0008) and WD_MARGIN=64.
REQ-037 The round-robin selector SHALL be a sub-module, rr_arbiter (req vector and last-grant input; one-hot grant and index output).

Verification
REQ-038 Bench: single req[1] with delay=100 -> writes to addresses 2,3,1,0 with data 100,0,5,0; done[1] pulse at 107 cycles after grant.
REQ-039 Bench: req=4'b1111 in the same cycle, each delay=10 -> grant order 0,1,2,3, then 0 again while req[0] is still held.
REQ-040 Bench: req[2] with delay=0 -> no timer writes; done[2] 2 cycles after req.
REQ-041 Bench: delay=32'h0001_0000 -> period_l=0, period_h=1; done after 65543 cycles.
REQ-042 Bench: reset_n pulsed low during WAIT_IRQ -> all outputs at reset values, no done pulse, next req served normally.
REQ-043 Bench: with TIMER_SCHED_WATCHDOG_EN and tmr_irq forced low, delay=20 -> STOP write after 84 cycles in WAIT_IRQ, then status clear and err[id] pulse with done=0.
